// File: rtl/sdram_ctrl.sv
// SDRAM controller sequencing: power-up init, then refresh/write/read bursts
// scheduled from a single state-duration timer.
module sdram_ctrl #(
  parameter int INIT_WAIT  = 20000,
  parameter int REF_PERIOD = 780,
  parameter int TRP_CLK    = 4,
  parameter int TRC_CLK    = 6,
  parameter int TRSC_CLK   = 6,
  parameter int TRCD_CLK   = 2,
  parameter int TCL_CLK    = 3,
  parameter int TWR_CLK    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdram_wr_req,
  input  logic       sdram_rd_req,
  input  logic [9:0] sdram_wr_burst,
  input  logic [9:0] sdram_rd_burst,
  output logic       sdram_wr_ack,
  output logic       sdram_rd_ack,
  output logic       sdram_init_done,
  output logic [2:0] init_state,
  output logic [3:0] work_state,
  output logic [9:0] cnt_clk
);

  localparam logic [2:0] I_NOP  = 3'd0;
  localparam logic [2:0] I_PRE  = 3'd1;
  localparam logic [2:0] I_TRP  = 3'd2;
  localparam logic [2:0] I_AR   = 3'd3;
  localparam logic [2:0] I_TRF  = 3'd4;
  localparam logic [2:0] I_MRS  = 3'd5;
  localparam logic [2:0] I_TRSC = 3'd6;
  localparam logic [2:0] I_DONE = 3'd7;

  localparam logic [3:0] W_IDLE   = 4'd0;
  localparam logic [3:0] W_ACTIVE = 4'd1;
  localparam logic [3:0] W_TRCD   = 4'd2;
  localparam logic [3:0] W_READ   = 4'd3;
  localparam logic [3:0] W_CL     = 4'd4;
  localparam logic [3:0] W_RD     = 4'd5;
  localparam logic [3:0] W_WRITE  = 4'd6;
  localparam logic [3:0] W_WD     = 4'd7;
  localparam logic [3:0] W_TWR    = 4'd8;
  localparam logic [3:0] W_PRE    = 4'd9;
  localparam logic [3:0] W_TRP    = 4'd10;
  localparam logic [3:0] W_AR     = 4'd11;
  localparam logic [3:0] W_TRFC   = 4'd12;

  // Timer value on the last cycle of each timed state.
  localparam logic [31:0] T_INIT = 32'(INIT_WAIT - 1);
  localparam logic [31:0] T_TRP  = 32'(TRP_CLK - 1);
  localparam logic [31:0] T_TRC  = 32'(TRC_CLK - 1);
  localparam logic [31:0] T_TRSC = 32'(TRSC_CLK - 1);
  localparam logic [31:0] T_TRCD = 32'(TRCD_CLK - 1);
  localparam logic [31:0] T_CL   = 32'(TCL_CLK - 2);
  localparam logic [31:0] T_TWR  = 32'(TWR_CLK - 1);
  localparam logic [31:0] T_REF  = 32'(REF_PERIOD - 1);

  logic [2:0]  init_reg, init_next;
  logic [3:0]  work_reg, work_next;
  logic [31:0] timer_reg, timer_next;
  logic [2:0]  ar_cnt_reg, ar_cnt_next;
  logic [31:0] ref_cnt_reg, ref_cnt_next;
  logic        ref_pending_reg, ref_pending_next;
  logic [9:0]  burst_reg, burst_next;
  logic        is_write_reg, is_write_next;
  logic        rd_ack_reg;

  logic init_done;
  logic ref_wrap;
  logic ref_req;
  logic wd_last;
  logic rd_last;

  assign init_done = (init_reg == I_DONE);
  assign ref_wrap  = init_done && (ref_cnt_reg == T_REF);
  // A wrap in the idle decision cycle counts as pending so refresh wins that edge.
  assign ref_req   = ref_pending_reg | ref_wrap;
  assign wd_last   = (timer_reg == ({22'd0, burst_reg} - 32'd2));
  assign rd_last   = (timer_reg == ({22'd0, burst_reg} - 32'd1));

  always_comb begin
    init_next   = init_reg;
    ar_cnt_next = ar_cnt_reg;
    case (init_reg)
      I_NOP:  if (timer_reg == T_INIT) init_next = I_PRE;
      I_PRE:  init_next = I_TRP;
      I_TRP:  if (timer_reg == T_TRP) init_next = I_AR;
      I_AR:   init_next = I_TRF;
      I_TRF: begin
        if (timer_reg == T_TRC) begin
          init_next   = (ar_cnt_reg == 3'd7) ? I_MRS : I_AR;
          ar_cnt_next = ar_cnt_reg + 3'd1;
        end
      end
      I_MRS:  init_next = I_TRSC;
      I_TRSC: if (timer_reg == T_TRSC) init_next = I_DONE;
      default: init_next = I_DONE;
    endcase
  end

  always_comb begin
    work_next     = work_reg;
    burst_next    = burst_reg;
    is_write_next = is_write_reg;
    case (work_reg)
      W_IDLE: begin
        if (init_done) begin
          if (ref_req) begin
            work_next = W_AR;
          end else if (sdram_wr_req) begin
            work_next     = W_ACTIVE;
            is_write_next = 1'b1;
            burst_next    = (sdram_wr_burst == 10'd0) ? 10'd1 : sdram_wr_burst;
          end else if (sdram_rd_req) begin
            work_next     = W_ACTIVE;
            is_write_next = 1'b0;
            burst_next    = (sdram_rd_burst == 10'd0) ? 10'd1 : sdram_rd_burst;
          end
        end
      end
      W_ACTIVE: work_next = W_TRCD;
      W_TRCD:   if (timer_reg == T_TRCD) work_next = is_write_reg ? W_WRITE : W_READ;
      W_WRITE:  work_next = (burst_reg <= 10'd1) ? W_TWR : W_WD;
      W_WD:     if (wd_last) work_next = W_TWR;
      W_TWR:    if (timer_reg == T_TWR) work_next = W_PRE;
      W_READ:   work_next = (TCL_CLK > 1) ? W_CL : W_RD;
      W_CL:     if (timer_reg == T_CL) work_next = W_RD;
      W_RD:     if (rd_last) work_next = W_PRE;
      W_PRE:    work_next = W_TRP;
      W_TRP:    if (timer_reg == T_TRP) work_next = W_IDLE;
      W_AR:     work_next = W_TRFC;
      W_TRFC:   if (timer_reg == T_TRC) work_next = W_IDLE;
      default:  work_next = W_IDLE;
    endcase
  end

  always_comb begin
    if ((init_next != init_reg) || (work_next != work_reg)) begin
      timer_next = 32'd0;
    end else if (timer_reg == 32'hFFFF_FFFF) begin
      timer_next = timer_reg;
    end else begin
      timer_next = timer_reg + 32'd1;
    end

    if (!init_done) begin
      ref_cnt_next = 32'd0;
    end else if (ref_wrap) begin
      ref_cnt_next = 32'd0;
    end else begin
      ref_cnt_next = ref_cnt_reg + 32'd1;
    end

    if ((work_reg == W_IDLE) && (work_next == W_AR)) begin
      ref_pending_next = 1'b0;
    end else if (ref_wrap) begin
      ref_pending_next = 1'b1;
    end else begin
      ref_pending_next = ref_pending_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_reg        <= I_NOP;
      work_reg        <= W_IDLE;
      timer_reg       <= 32'd0;
      ar_cnt_reg      <= 3'd0;
      ref_cnt_reg     <= 32'd0;
      ref_pending_reg <= 1'b0;
      burst_reg       <= 10'd0;
      is_write_reg    <= 1'b0;
      rd_ack_reg      <= 1'b0;
    end else begin
      init_reg        <= init_next;
      work_reg        <= work_next;
      timer_reg       <= timer_next;
      ar_cnt_reg      <= ar_cnt_next;
      ref_cnt_reg     <= ref_cnt_next;
      ref_pending_reg <= ref_pending_next;
      burst_reg       <= burst_next;
      is_write_reg    <= is_write_next;
      rd_ack_reg      <= (work_reg == W_RD);
    end
  end

  assign sdram_wr_ack    = (work_reg == W_WRITE) || (work_reg == W_WD);
  assign sdram_rd_ack    = rd_ack_reg;
  assign sdram_init_done = init_done;
  assign init_state      = init_reg;
  assign work_state      = work_reg;
  assign cnt_clk         = (|timer_reg[31:10]) ? 10'h3FF : timer_reg[9:0];

endmodule

// File: tb/tb_sdram_ctrl.sv
// Bench for sdram_ctrl: directed burst table, hand-written corner sequences,
// then random requests checked cycle by cycle against an expected-trace model.
module tb_sdram_ctrl;

  localparam int INIT_WAIT  = 10;
  localparam int REF_PERIOD = 100;
  localparam int TRP = 4, TRC = 6, TRSC = 6, TRCD = 2, TCL = 3, TWR = 2;
  localparam int INIT_CYCLES = INIT_WAIT + 1 + TRP + 8 * (1 + TRC) + 1 + TRSC;

  localparam int I_NOP = 0, I_PRE = 1, I_TRP = 2, I_AR = 3, I_TRF = 4, I_MRS = 5, I_TRSC = 6, I_DONE = 7;
  localparam int W_IDLE = 0, W_ACTIVE = 1, W_TRCD = 2, W_READ = 3, W_CL = 4, W_RD = 5, W_WRITE = 6;
  localparam int W_WD = 7, W_TWR = 8, W_PRE = 9, W_TRP = 10, W_AR = 11, W_TRFC = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_req = 1'b0, rd_req = 1'b0;
  logic [9:0] wr_burst = 10'd0, rd_burst = 10'd0;
  logic       wr_ack, rd_ack, init_done;
  logic [2:0] init_state;
  logic [3:0] work_state;
  logic [9:0] cnt_clk;

  always #5 clk = ~clk;

  sdram_ctrl #(.INIT_WAIT(INIT_WAIT), .REF_PERIOD(REF_PERIOD)) dut (
    .clk(clk), .rst(rst),
    .sdram_wr_req(wr_req), .sdram_rd_req(rd_req),
    .sdram_wr_burst(wr_burst), .sdram_rd_burst(rd_burst),
    .sdram_wr_ack(wr_ack), .sdram_rd_ack(rd_ack),
    .sdram_init_done(init_done), .init_state(init_state),
    .work_state(work_state), .cnt_clk(cnt_clk)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_and_release();
    @(negedge clk);
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    check("reset_state", int'({init_state, work_state, cnt_clk, wr_ack, rd_ack, init_done}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int ar_visits);
    logic [2:0] prev_init;
    prev_init = init_state;
    edges = 0;
    ar_visits = 0;
    while (!init_done && edges < 300) begin
      @(negedge clk);
      edges++;
      if (init_state == 3'(I_AR) && prev_init != 3'(I_AR)) ar_visits++;
      prev_init = init_state;
    end
  endtask

  // Directed bursts: each starts from a fresh init so refresh never intervenes.
  typedef struct {
    logic wr; logic rd; int wb; int rb;
    int e_wr_ack; int e_rd_ack; int e_wd; int e_cl; int e_rd; int e_busy;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int edges, ars, busy, nwr, nrd, nwd, ncl, nrdst, misalign;
    logic prev_rd;
    reset_and_release();
    wait_done(edges, ars);
    check("init_cycles", edges, INIT_CYCLES);
    check("ar_visits", ars, 8);
    wr_req = v.wr; rd_req = v.rd; wr_burst = 10'(v.wb); rd_burst = 10'(v.rb);
    @(negedge clk);
    check("grant", int'(work_state), W_ACTIVE);
    wr_req = 1'b0; rd_req = 1'b0; wr_burst = 10'd37; rd_burst = 10'd37;
    busy = 0; nwr = 0; nrd = 0; nwd = 0; ncl = 0; nrdst = 0; misalign = 0; prev_rd = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (rd_ack != prev_rd) misalign++;
      if (work_state == 4'(W_IDLE)) break;
      busy++;
      nwr += int'(wr_ack);
      nrd += int'(rd_ack);
      nwd += int'(work_state == 4'(W_WD));
      ncl += int'(work_state == 4'(W_CL));
      nrdst += int'(work_state == 4'(W_RD));
      prev_rd = (work_state == 4'(W_RD));
      @(negedge clk);
    end
    $display("vec %0d: wr=%0b rd=%0b busy=%0d wr_acks=%0d rd_acks=%0d", idx, v.wr, v.rd, busy, nwr, nrd);
    check("busy_cycles", busy, v.e_busy);
    check("wr_ack_count", nwr, v.e_wr_ack);
    check("rd_ack_count", nrd, v.e_rd_ack);
    check("wd_cycles", nwd, v.e_wd);
    check("cl_cycles", ncl, v.e_cl);
    check("rd_cycles", nrdst, v.e_rd);
    check("rd_ack_align", misalign, 0);
  endtask

  // Expected-trace model: each granted operation expands into its list of cycles.
  typedef struct packed { logic [2:0] init; logic [3:0] work; logic wr; logic rd; } rec_t;
  rec_t q[$];

  task automatic push_n(input int s_init, input int s_work, input int n, input bit w, input bit r);
    rec_t e;
    e.init = 3'(s_init); e.work = 4'(s_work); e.wr = w; e.rd = r;
    for (int k = 0; k < n; k++) q.push_back(e);
  endtask

  task automatic push_write(input int b);
    int b0;
    b0 = (b == 0) ? 1 : b;
    push_n(I_DONE, W_ACTIVE, 1, 0, 0);
    push_n(I_DONE, W_TRCD, TRCD, 0, 0);
    push_n(I_DONE, W_WRITE, 1, 1, 0);
    push_n(I_DONE, W_WD, b0 - 1, 1, 0);
    push_n(I_DONE, W_TWR, TWR, 0, 0);
    push_n(I_DONE, W_PRE, 1, 0, 0);
    push_n(I_DONE, W_TRP, TRP, 0, 0);
  endtask

  task automatic push_read(input int b);
    int b0;
    b0 = (b == 0) ? 1 : b;
    push_n(I_DONE, W_ACTIVE, 1, 0, 0);
    push_n(I_DONE, W_TRCD, TRCD, 0, 0);
    push_n(I_DONE, W_READ, 1, 0, 0);
    push_n(I_DONE, W_CL, TCL - 1, 0, 0);
    push_n(I_DONE, W_RD, 1, 0, 0);
    push_n(I_DONE, W_RD, b0 - 1, 0, 1);
    push_n(I_DONE, W_PRE, 1, 0, 1);
    push_n(I_DONE, W_TRP, TRP, 0, 0);
  endtask

  task automatic random_phase(input int cycles);
    rec_t cur;
    bit idle, wrap, pending, wr_grant, rd_grant;
    int done_idx, prev_key, key, exp_cnt;
    logic [19:0] act, exp;
    q.delete();
    push_n(I_NOP, W_IDLE, INIT_WAIT, 0, 0);
    push_n(I_PRE, W_IDLE, 1, 0, 0);
    push_n(I_TRP, W_IDLE, TRP, 0, 0);
    for (int k = 0; k < 8; k++) begin
      push_n(I_AR, W_IDLE, 1, 0, 0);
      push_n(I_TRF, W_IDLE, TRC, 0, 0);
    end
    push_n(I_MRS, W_IDLE, 1, 0, 0);
    push_n(I_TRSC, W_IDLE, TRSC, 0, 0);
    pending = 0; wr_grant = 0; rd_grant = 0; done_idx = 0; prev_key = -1; exp_cnt = 0;
    reset_and_release();
    for (int c = 0; c < cycles; c++) begin
      if (q.size() > 0) begin
        cur = q.pop_front(); idle = 0;
      end else begin
        cur.init = 3'(I_DONE); cur.work = 4'(W_IDLE); cur.wr = 1'b0; cur.rd = 1'b0; idle = 1;
      end
      key = int'({cur.init, cur.work});
      exp_cnt = (key != prev_key) ? 0 : ((exp_cnt < 1023) ? exp_cnt + 1 : 1023);
      prev_key = key;
      act = {init_state, work_state, cnt_clk, wr_ack, rd_ack, init_done};
      exp = {cur.init, cur.work, 10'(exp_cnt), cur.wr, cur.rd, cur.init == 3'(I_DONE)};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL rand cycle %0d: got init=%0d work=%0d cnt=%0d wr=%0b rd=%0b done=%0b expected init=%0d work=%0d cnt=%0d wr=%0b rd=%0b done=%0b",
                 c, init_state, work_state, cnt_clk, wr_ack, rd_ack, init_done,
                 cur.init, cur.work, exp_cnt, cur.wr, cur.rd, cur.init == 3'(I_DONE));
      end
      if (wr_grant) begin wr_req = 1'b0; wr_burst = 10'($urandom_range(0, 1023)); wr_grant = 0; end
      if (rd_grant) begin rd_req = 1'b0; rd_burst = 10'($urandom_range(0, 1023)); rd_grant = 0; end
      if (!wr_req && $urandom_range(0, 5) == 0) begin wr_req = 1'b1; wr_burst = 10'($urandom_range(0, 12)); end
      if (!rd_req && $urandom_range(0, 5) == 0) begin rd_req = 1'b1; rd_burst = 10'($urandom_range(0, 12)); end
      wrap = (cur.init == 3'(I_DONE)) && (done_idx % REF_PERIOD == REF_PERIOD - 1);
      if (cur.init == 3'(I_DONE)) done_idx++;
      if (idle) begin
        if (pending || wrap) begin
          push_n(I_DONE, W_AR, 1, 0, 0);
          push_n(I_DONE, W_TRFC, TRC, 0, 0);
          pending = 0;
        end else if (wr_req) begin
          push_write(int'(wr_burst)); wr_grant = 1;
        end else if (rd_req) begin
          push_read(int'(rd_burst)); rd_grant = 1;
        end
      end else if (wrap) begin
        pending = 1;
      end
      @(negedge clk);
      if (bad > 20) break;
    end
    $display("random: %0d cycles compared, done cycles=%0d", cycles, done_idx);
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    vec_t vecs[7];
    int edges, ars, order, n;
    bit seen_w, seen_r;
    logic [3:0] prev_work;

    vecs[0] = '{1'b1, 1'b0, 4,  0, 4,  0, 3, 0, 0, 14};
    vecs[1] = '{1'b0, 1'b1, 0,  8, 0,  8, 0, 2, 8, 19};
    vecs[2] = '{1'b1, 1'b0, 0,  0, 1,  0, 0, 0, 0, 11};
    vecs[3] = '{1'b0, 1'b1, 0,  0, 0,  1, 0, 2, 1, 12};
    vecs[4] = '{1'b1, 1'b0, 1,  0, 1,  0, 0, 0, 0, 11};
    vecs[5] = '{1'b0, 1'b1, 0,  3, 0,  3, 0, 2, 3, 14};
    vecs[6] = '{1'b1, 1'b0, 10, 0, 10, 0, 9, 0, 0, 20};

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Both requests arrive in the refresh-wrap cycle: refresh, then write, then read.
    reset_and_release();
    wait_done(edges, ars);
    repeat (REF_PERIOD - 1) @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b1; wr_burst = 10'd2; rd_burst = 10'd2;
    @(negedge clk);
    check("ref_first", int'(work_state), W_AR);
    order = 1; seen_w = 0; seen_r = 0; prev_work = work_state; n = 0;
    while (!(seen_r && work_state == 4'(W_IDLE)) && n < 200) begin
      @(negedge clk);
      n++;
      if (work_state == 4'(W_AR) && prev_work != 4'(W_AR)) order = order * 10 + 1;
      if (work_state == 4'(W_WRITE)) begin order = order * 10 + 2; seen_w = 1; wr_req = 1'b0; end
      if (work_state == 4'(W_READ)) begin order = order * 10 + 3; seen_r = 1; rd_req = 1'b0; end
      prev_work = work_state;
    end
    $display("arbitration: order code=%0d after %0d cycles", order, n);
    check("arb_order", order, 123);
    wr_req = 1'b0; rd_req = 1'b0;

    // Reset during a long write burst aborts and re-runs init.
    reset_and_release();
    wait_done(edges, ars);
    wr_req = 1'b1; wr_burst = 10'd16;
    n = 0;
    while (work_state != 4'(W_WD) && n < 50) begin @(negedge clk); n++; end
    wr_req = 1'b0;
    repeat (3) @(negedge clk);
    check("wd_ack_before_rst", int'(wr_ack), 1);
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-burst: init=%0d work=%0d wr_ack=%0b", init_state, work_state, wr_ack);
    check("rst_wr_ack", int'(wr_ack), 0);
    check("rst_work_state", int'(work_state), W_IDLE);
    check("rst_init_state", int'(init_state), I_NOP);
    check("rst_cnt_clk", int'(cnt_clk), 0);
    check("rst_init_done", int'(init_done), 0);
    rst = 1'b0;
    wait_done(edges, ars);
    check("reinit_cycles", edges, INIT_CYCLES);
    check("reinit_ar_visits", ars, 8);

    random_phase(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
